// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq
//   Replays a solved knight's tour into cmd_proc and arbitrates the cmd_proc
//   command port between the UART/BLE path and tour replay. Each stored
//   one-hot knight move becomes two commands: a vertical MOVE leg, then a
//   horizontal MOVE-with-fanfare leg.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start_tour         pulse from cmd_proc: begin replay
//   move / mv_indx     one-hot move read combinationally from tour memory
//   cmd_UART,
//   cmd_rdy_UART,
//   clr_cmd_rdy_UART   command handshake with the UART wrapper
//   cmd, cmd_rdy,
//   clr_cmd_rdy        command handshake with cmd_proc
//   send_resp          cmd_proc finished the current command
//   resp               response byte (8'hA5 intermediate, 8'h5A complete)
//   tour_busy          high while replay owns the command port
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy
);

  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_FAN  = 4'h3;
  localparam logic [7:0] HEAD_N  = 8'h00;
  localparam logic [7:0] HEAD_W  = 8'h3F;
  localparam logic [7:0] HEAD_S  = 8'h7F;
  localparam logic [7:0] HEAD_E  = 8'hBF;
  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  // Lowest set bit wins when the stored move is not strictly one-hot.
  function automatic logic signed [2:0] move_dx(input logic [7:0] mv);
    casez (mv)
      8'b???????1: move_dx =  3'sd1;
      8'b??????10: move_dx = -3'sd1;
      8'b?????100: move_dx = -3'sd2;
      8'b????1000: move_dx = -3'sd2;
      8'b???10000: move_dx = -3'sd1;
      8'b??100000: move_dx =  3'sd1;
      8'b?1000000: move_dx =  3'sd2;
      8'b10000000: move_dx =  3'sd2;
      default:     move_dx =  3'sd0;
    endcase
  endfunction

  function automatic logic signed [2:0] move_dy(input logic [7:0] mv);
    casez (mv)
      8'b???????1: move_dy =  3'sd2;
      8'b??????10: move_dy =  3'sd2;
      8'b?????100: move_dy =  3'sd1;
      8'b????1000: move_dy = -3'sd1;
      8'b???10000: move_dy = -3'sd2;
      8'b??100000: move_dy = -3'sd2;
      8'b?1000000: move_dy = -3'sd1;
      8'b10000000: move_dy =  3'sd1;
      default:     move_dy =  3'sd0;
    endcase
  endfunction

  function automatic logic [3:0] magnitude(input logic signed [2:0] d);
    logic [2:0] m;
    m = d[2] ? 3'(-d) : 3'(d);
    return {1'b0, m};
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic signed [2:0]  dx, dy;
  logic [15:0]        vert_cmd, horz_cmd;

  always_comb begin
    dx = move_dx(move);
    dy = move_dy(move);
    vert_cmd = {OP_MOVE, (dy > 3'sd0) ? HEAD_N : HEAD_S, magnitude(dy)};
    horz_cmd = {OP_FAN,  (dx > 3'sd0) ? HEAD_E : HEAD_W, magnitude(dx)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_ACK;
    tour_busy        = 1'b1;
    unique case (state_q)
      IDLE: begin
        // UART path owns the port; a UART command left pending during a
        // tour shows up here on the first idle cycle.
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        tour_busy        = 1'b0;
        if (start_tour) begin
          idx_d   = '0;
          state_d = VERT;
        end
      end
      VERT: begin
        cmd = vert_cmd;
        if (move == 8'h00) begin
          // Empty memory entry: nothing to replay, give the port back.
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = HOLD_V;
        end
      end
      HOLD_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_H;
      end
      HOLD_H: begin
        cmd = horz_cmd;
        if (idx_q == LAST_IDX) resp = RESP_DONE;
        if (send_resp) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv_indx = idx_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
module tb_tour_cmd_seq;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  logic             clk;
  logic             rst_n;
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy_UART;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [7:0]       resp;
  logic             tour_busy;

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .tour_busy        (tour_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tour memory model: move read combinationally at mv_indx.
  logic [7:0] tour_mem [NUM_MOVES];
  logic       use_mem;
  logic [7:0] move_ovr;

  always_comb begin
    move = move_ovr;
    if (use_mem) move = (int'(mv_indx) < NUM_MOVES) ? tour_mem[mv_indx] : 8'h00;
  end

  // Hand-computed legs per winning bit: {vertical, horizontal}.
  logic [15:0] v_exp [8];
  logic [15:0] h_exp [8];

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // One clock; pulses drop right after the edge, outputs settle before checks.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    start_tour  = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", tour_busy, 1'b0);
    check("rst_idx",  mv_indx,   '0);
    check("rst_resp", resp,      8'h5A);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic start();
    start_tour = 1'b1;
    cyc();
  endtask

  // Full handshake of one stored move with checks at every state.
  task automatic replay_move(input int i);
    int b;
    b = (i == 6) ? 3 : (i % 8);
    check("v_idx",  mv_indx,          i[IDX_W-1:0]);
    check("v_cmd",  cmd,              v_exp[b]);
    check("v_rdy",  cmd_rdy,          1'b1);
    check("v_resp", resp,             8'hA5);
    check("v_clru", clr_cmd_rdy_UART, 1'b0);
    clr_cmd_rdy = 1'b1;
    if (i == 2) send_resp = 1'b1;  // simultaneous: send_resp must be dropped
    cyc();
    check("hv_rdy",  cmd_rdy, 1'b0);
    check("hv_busy", tour_busy, 1'b1);
    if (i == 2 || i == 4) begin
      if (i == 4) clr_cmd_rdy = 1'b1;  // ignored in HOLD_V
      cyc();
      check("hv_stay", cmd_rdy, 1'b0);
    end
    send_resp = 1'b1;
    cyc();
    check("h_cmd",  cmd,     h_exp[b]);
    check("h_rdy",  cmd_rdy, 1'b1);
    check("h_resp", resp,    8'hA5);
    clr_cmd_rdy = 1'b1;
    cyc();
    check("hh_rdy",  cmd_rdy, 1'b0);
    check("hh_resp", resp, (i == NUM_MOVES - 1) ? 8'h5A : 8'hA5);
    if (i == 3) begin
      start_tour = 1'b1;  // ignored while busy
      cyc();
      check("hh_start_idx", mv_indx, i[IDX_W-1:0]);
      check("hh_start_rdy", cmd_rdy, 1'b0);
    end
    send_resp = 1'b1;
    cyc();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    v_exp[0] = 16'h2002; h_exp[0] = 16'h3BF1;
    v_exp[1] = 16'h2002; h_exp[1] = 16'h33F1;
    v_exp[2] = 16'h2001; h_exp[2] = 16'h33F2;
    v_exp[3] = 16'h27F1; h_exp[3] = 16'h33F2;
    v_exp[4] = 16'h27F2; h_exp[4] = 16'h33F1;
    v_exp[5] = 16'h27F2; h_exp[5] = 16'h3BF1;
    v_exp[6] = 16'h27F1; h_exp[6] = 16'h3BF2;
    v_exp[7] = 16'h2001; h_exp[7] = 16'h3BF2;
    for (int i = 0; i < NUM_MOVES; i++) tour_mem[i] = 8'h01 << (i % 8);
    tour_mem[6] = 8'hC8;  // multi-bit entry, bit 3 wins

    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0; use_mem = 1'b0; move_ovr = 8'h01;
    #2;
    do_reset();

    // UART pass-through in IDLE
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h2001; clr_cmd_rdy = 1'b1;
    #1;
    check("pt_cmd",  cmd,              16'h2001);
    check("pt_rdy",  cmd_rdy,          1'b1);
    check("pt_clru", clr_cmd_rdy_UART, 1'b1);
    check("pt_resp", resp,             8'h5A);
    check("pt_busy", tour_busy,        1'b0);
    cyc();
    cmd_rdy_UART = 1'b0;

    // Single move 8'h01
    move_ovr = 8'h01;
    start();
    check("m1_v_cmd",  cmd,       16'h2002);
    check("m1_v_rdy",  cmd_rdy,   1'b1);
    check("m1_v_busy", tour_busy, 1'b1);
    check("m1_v_resp", resp,      8'hA5);
    send_resp = 1'b1;  // ignored in VERT
    cyc();
    check("m1_v_sr_ign", cmd_rdy, 1'b1);
    clr_cmd_rdy = 1'b1;
    cyc();
    check("m1_hv_resp", resp, 8'hA5);
    send_resp = 1'b1;
    cyc();
    check("m1_h_cmd",  cmd,     16'h3BF1);
    check("m1_h_rdy",  cmd_rdy, 1'b1);
    check("m1_h_resp", resp,    8'hA5);
    do_reset();

    // Single move 8'h08
    move_ovr = 8'h08;
    start();
    check("m8_v_cmd", cmd, 16'h27F1);
    clr_cmd_rdy = 1'b1; cyc();
    send_resp = 1'b1; cyc();
    check("m8_h_cmd", cmd, 16'h33F2);
    clr_cmd_rdy = 1'b1; cyc();
    send_resp = 1'b1; cyc();
    check("m8_idx",  mv_indx, 5'd1);
    check("m8_rdy",  cmd_rdy, 1'b1);
    check("m8_busy", tour_busy, 1'b1);
    do_reset();

    // Full replay with a UART command pending throughout
    use_mem = 1'b1;
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h2345;
    start();
    for (int i = 0; i < NUM_MOVES; i++) replay_move(i);
    check("end_busy", tour_busy,        1'b0);
    check("end_idx",  mv_indx,          5'd0);
    check("end_resp", resp,             8'h5A);
    check("end_cmd",  cmd,              16'h2345);
    check("end_rdy",  cmd_rdy,          1'b1);
    cmd_rdy_UART = 1'b0;

    // Reset while in HORZ at index 10
    start();
    for (int i = 0; i < 10; i++) replay_move(i);
    clr_cmd_rdy = 1'b1; cyc();
    send_resp = 1'b1; cyc();
    check("r10_idx", mv_indx, 5'd10);
    check("r10_cmd", cmd,     h_exp[2]);
    rst_n = 1'b0;
    #1;
    check("r10_busy", tour_busy, 1'b0);
    check("r10_idx0", mv_indx,   5'd0);
    check("r10_resp", resp,      8'h5A);
    @(posedge clk); #1; rst_n = 1'b1; #1;

    // Empty move aborts
    use_mem = 1'b0; move_ovr = 8'h00;
    start();
    check("z_rdy",  cmd_rdy,   1'b0);
    check("z_busy", tour_busy, 1'b1);
    cyc();
    check("z_idle", tour_busy, 1'b0);
    check("z_idx",  mv_indx,   5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
